// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit engine: LCR bit positions, FSM encoding,
// and helpers for the stop-bit length and the parity bit.
package uart_tx_engine_pkg;

  localparam int LC_BITS = 0;   // [1:0] word length - 5
  localparam int LC_SB   = 2;
  localparam int LC_PE   = 3;
  localparam int LC_EP   = 4;
  localparam int LC_SP   = 5;
  localparam int LC_BC   = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  function automatic int stop_ticks(input logic sb, input logic five_bits, input int os);
    if (!sb)      return os;
    if (five_bits) return (3 * os) / 2;
    return 2 * os;
  endfunction

  // {EP,SP}: 00 odd, 10 even, 01 stick-1, 11 stick-0
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] bits,
                                      input logic ep, input logic sp);
    logic [7:0] mask;
    logic       p;
    mask = 8'hFF >> (2'd3 - bits);
    p    = ^(d & mask);
    case ({ep, sp})
      2'b00:   return ~p;
      2'b10:   return p;
      2'b01:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Register-file side of the transmitter: THR/LCR/FCR controls in, LSR status out.
interface uart_tx_engine_if #(parameter int CNT_W = 5);
  logic [7:0]       lcr;
  logic [7:0]       wb_dat_i;
  logic             tf_push;
  logic             tx_reset;
  logic             lsr_mask;
  logic [CNT_W-1:0] tf_count;
  logic             tf_overrun;
  logic             thre;
  logic             temt;

  modport master (output lcr, wb_dat_i, tf_push, tx_reset, lsr_mask,
                  input  tf_count, tf_overrun, thre, temt);
  modport slave  (input  lcr, wb_dat_i, tf_push, tx_reset, lsr_mask,
                  output tf_count, tf_overrun, thre, temt);
endinterface

// File: rtl/uart_tx_engine_fifo.sv
// Circular TX FIFO with synchronous flush, occupancy count and sticky overrun flag.
module uart_tx_engine_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overrun;
  logic             w_full, w_empty, w_do_pop, w_do_push, w_ovr_set;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
  // A pop in the same clk frees the slot, so a push into a full FIFO is still legal
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);
  assign w_ovr_set = i_push & ~i_flush & w_full & ~w_do_pop;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_wptr <= r_wptr + AW'(1);
        if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (i_ovr_clr) r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  assign o_dout    = r_mem[r_rptr];
  assign o_count   = r_count;
  assign o_overrun = r_overrun;
endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-fed serialiser with per-frame latched line format,
// CTS auto flow control and back-to-back framing.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                wb_rst_i,
  uart_tx_engine_if.slave     bus,
  input  logic                enable,
  input  logic                afe,
  input  logic                cts_n,
  output logic                stx_pad_o,
  output logic [2:0]          tstate
);
  localparam int             TW     = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0]  BIT_M1 = TW'(OVERSAMPLE - 1);

  tx_state_e        r_state, w_next;
  logic [TW-1:0]    r_cnt, w_cnt_nxt;
  logic [TW-1:0]    r_stop_m1;
  logic [7:0]       r_shift;
  logic [2:0]       r_bits;
  logic             r_pe, r_par;
  logic [7:0]       w_dout;
  logic             w_nonempty, w_go, w_latch, w_bit_end, w_line;
  logic             w_unused;

  assign w_unused   = bus.lcr[7];
  assign w_nonempty = (bus.tf_count != '0);
  assign w_go       = w_nonempty & ~(afe & cts_n);
  assign w_bit_end  = (r_cnt == '0);
  // The POP tick both pops the FIFO and captures the head word with the current format
  assign w_latch    = enable & (r_state == ST_POP) & w_nonempty;

  uart_tx_engine_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .i_push    (bus.tf_push),
    .i_din     (bus.wb_dat_i),
    .i_pop     (w_latch),
    .i_flush   (bus.tx_reset),
    .i_ovr_clr (bus.lsr_mask),
    .o_dout    (w_dout),
    .o_count   (bus.tf_count),
    .o_overrun (bus.tf_overrun)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    if (enable) begin
      unique case (r_state)
        ST_IDLE: if (w_go) begin
          w_next    = ST_POP;
          w_cnt_nxt = '0;
        end
        ST_POP: begin
          w_next    = w_nonempty ? ST_START : ST_IDLE;
          w_cnt_nxt = w_nonempty ? BIT_M1 : '0;
        end
        ST_START: begin
          if (w_bit_end) begin
            w_next    = ST_DATA;
            w_cnt_nxt = BIT_M1;
          end else w_cnt_nxt = r_cnt - TW'(1);
        end
        ST_DATA: begin
          if (w_bit_end) begin
            w_cnt_nxt = BIT_M1;
            if (r_bits == '0) begin
              if (r_pe) w_next = ST_PARITY;
              else begin
                w_next    = ST_STOP;
                w_cnt_nxt = r_stop_m1;
              end
            end
          end else w_cnt_nxt = r_cnt - TW'(1);
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            w_next    = ST_STOP;
            w_cnt_nxt = r_stop_m1;
          end else w_cnt_nxt = r_cnt - TW'(1);
        end
        ST_STOP: begin
          if (w_bit_end) begin
            w_next    = w_go ? ST_POP : ST_IDLE;
            w_cnt_nxt = '0;
          end else w_cnt_nxt = r_cnt - TW'(1);
        end
        default: begin
          w_next    = ST_IDLE;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_stop_m1 <= '0;
      r_shift   <= '0;
      r_bits    <= '0;
      r_pe      <= 1'b0;
      r_par     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_shift   <= w_dout;
        r_bits    <= 3'd4 + {1'b0, bus.lcr[1:0]};
        r_pe      <= bus.lcr[LC_PE];
        r_par     <= parity_bit(w_dout, bus.lcr[1:0], bus.lcr[LC_EP], bus.lcr[LC_SP]);
        r_stop_m1 <= TW'(stop_ticks(bus.lcr[LC_SB], bus.lcr[1:0] == 2'd0, OVERSAMPLE) - 1);
      end else if (enable && r_state == ST_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
        r_bits  <= r_bits - 3'd1;
      end
    end
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_shift[0];
      ST_PARITY: w_line = r_par;
      default:   w_line = 1'b1;
    endcase
  end

  // Break overrides the line without stalling the serialiser
  assign stx_pad_o = bus.lcr[LC_BC] ? 1'b0 : w_line;
  assign tstate    = r_state;
  assign bus.thre  = ~w_nonempty;
  assign bus.temt  = ~w_nonempty & (r_state == ST_IDLE);
endmodule
